// File: rtl/id_ex_issue.sv
// id_ex_issue: ID-to-EX issue stage.
// Decodes a MIPS instruction into a 20-bit one-hot ALU control word plus its
// two ALU operands, and holds the result in a single ID/EX pipeline register
// behind a valid/ready handshake. Supports flush and counts issued entries.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   flush                 kill the in-flight entry and drop the current input
//   in_valid / in_ready   ID-side handshake (in_ready = !out_valid || out_ready)
//   in_pc, in_inst        instruction PC and word
//   in_rs_value/rt_value  forwarded GPR[rs] / GPR[rt]
//   out_valid / out_ready EX-side handshake
//   out_pc ... out_illegal registered decoded payload
//   out_issue_cnt         number of completed output handshakes (wraps)
module id_ex_issue #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_inst,
  input  logic [31:0]      in_rs_value,
  input  logic [31:0]      in_rt_value,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [19:0]      out_alu_control,
  output logic [31:0]      out_alu_src1,
  output logic [31:0]      out_alu_src2,
  output logic [4:0]       out_dest,
  output logic             out_reg_we,
  output logic             out_mem_re,
  output logic             out_mem_we,
  output logic [31:0]      out_store_data,
  output logic             out_illegal,
  output logic [CNT_W-1:0] out_issue_cnt
);

  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_BEQ  = 6'h04,
                         OP_BNE     = 6'h05, OP_BLEZ   = 6'h06, OP_BGTZ = 6'h07,
                         OP_ADDIU   = 6'h09, OP_SLTI   = 6'h0A, OP_SLTIU = 6'h0B,
                         OP_ANDI    = 6'h0C, OP_ORI    = 6'h0D, OP_XORI = 6'h0E,
                         OP_LUI     = 6'h0F, OP_LW     = 6'h23, OP_SW   = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA  = 6'h03,
                         FN_SLLV = 6'h04, FN_SRLV = 6'h06, FN_SRAV = 6'h07,
                         FN_ADDU = 6'h21, FN_SUBU = 6'h23, FN_AND  = 6'h24,
                         FN_OR   = 6'h25, FN_XOR  = 6'h26, FN_NOR  = 6'h27,
                         FN_SLT  = 6'h2A, FN_SLTU = 6'h2B;

  localparam logic [19:0] ALU_ADD  = 20'h00001, ALU_SUB  = 20'h00002, ALU_SLT  = 20'h00004,
                          ALU_SLTU = 20'h00008, ALU_AND  = 20'h00010, ALU_NOR  = 20'h00020,
                          ALU_OR   = 20'h00040, ALU_XOR  = 20'h00080, ALU_SLL  = 20'h00100,
                          ALU_SRL  = 20'h00200, ALU_SRA  = 20'h00400, ALU_LUI  = 20'h00800,
                          ALU_BLTZ = 20'h04000, ALU_BLEZ = 20'h08000, ALU_BGTZ = 20'h10000,
                          ALU_BGEZ = 20'h20000, ALU_BEQ  = 20'h40000, ALU_BNE  = 20'h80000;

  logic [5:0]  w_op, w_funct;
  logic [4:0]  w_rt, w_rd, w_shamt;
  logic [31:0] w_imm_sext, w_imm_zext;

  logic [19:0] w_dec_alu;
  logic [31:0] w_dec_src1, w_dec_src2;
  logic [4:0]  w_dec_dest;
  logic        w_dec_writes, w_dec_re, w_dec_we, w_dec_illegal;

  logic [19:0] w_alu;
  logic [31:0] w_src2;
  logic [4:0]  w_dest;
  logic        w_reg_we, w_mem_re, w_mem_we;

  logic        w_capture, w_fire;

  logic             r_valid;
  logic [31:0]      r_pc, r_src1, r_src2, r_store;
  logic [19:0]      r_alu;
  logic [4:0]       r_dest;
  logic             r_reg_we, r_mem_re, r_mem_we, r_illegal;
  logic [CNT_W-1:0] r_cnt;

  assign w_op       = in_inst[31:26];
  assign w_funct    = in_inst[5:0];
  assign w_rt       = in_inst[20:16];
  assign w_rd       = in_inst[15:11];
  assign w_shamt    = in_inst[10:6];
  assign w_imm_sext = {{16{in_inst[15]}}, in_inst[15:0]};
  assign w_imm_zext = {16'h0000, in_inst[15:0]};

  assign in_ready  = !r_valid || out_ready;
  assign w_capture = in_valid && in_ready && !flush;
  assign w_fire    = r_valid && out_ready;

  // Raw decode: ALU op, operand selection, destination and memory intent
  always_comb begin
    w_dec_alu     = 20'h00000;
    w_dec_src1    = in_rs_value;
    w_dec_src2    = in_rt_value;
    w_dec_dest    = 5'd0;
    w_dec_writes  = 1'b0;
    w_dec_re      = 1'b0;
    w_dec_we      = 1'b0;
    w_dec_illegal = 1'b0;
    case (w_op)
      OP_SPECIAL: begin
        w_dec_dest   = w_rd;
        w_dec_writes = 1'b1;
        case (w_funct)
          FN_ADDU: w_dec_alu = ALU_ADD;
          FN_SUBU: w_dec_alu = ALU_SUB;
          FN_SLT:  w_dec_alu = ALU_SLT;
          FN_SLTU: w_dec_alu = ALU_SLTU;
          FN_AND:  w_dec_alu = ALU_AND;
          FN_NOR:  w_dec_alu = ALU_NOR;
          FN_OR:   w_dec_alu = ALU_OR;
          FN_XOR:  w_dec_alu = ALU_XOR;
          FN_SLL:  begin w_dec_alu = ALU_SLL; w_dec_src1 = {27'd0, w_shamt}; end
          FN_SRL:  begin w_dec_alu = ALU_SRL; w_dec_src1 = {27'd0, w_shamt}; end
          FN_SRA:  begin w_dec_alu = ALU_SRA; w_dec_src1 = {27'd0, w_shamt}; end
          // variable shifts only use the low five bits of rs as the amount
          FN_SLLV: begin w_dec_alu = ALU_SLL; w_dec_src1 = {27'd0, in_rs_value[4:0]}; end
          FN_SRLV: begin w_dec_alu = ALU_SRL; w_dec_src1 = {27'd0, in_rs_value[4:0]}; end
          FN_SRAV: begin w_dec_alu = ALU_SRA; w_dec_src1 = {27'd0, in_rs_value[4:0]}; end
          default: w_dec_illegal = 1'b1;
        endcase
      end
      OP_REGIMM: begin
        w_dec_src2 = 32'd0;
        case (w_rt)
          5'd0:    w_dec_alu = ALU_BLTZ;
          5'd1:    w_dec_alu = ALU_BGEZ;
          default: w_dec_illegal = 1'b1;
        endcase
      end
      OP_BEQ:   w_dec_alu = ALU_BEQ;
      OP_BNE:   w_dec_alu = ALU_BNE;
      OP_BLEZ:  begin w_dec_alu = ALU_BLEZ; w_dec_src2 = 32'd0; end
      OP_BGTZ:  begin w_dec_alu = ALU_BGTZ; w_dec_src2 = 32'd0; end
      OP_ADDIU: begin w_dec_alu = ALU_ADD;  w_dec_src2 = w_imm_sext; w_dec_dest = w_rt; w_dec_writes = 1'b1; end
      OP_SLTI:  begin w_dec_alu = ALU_SLT;  w_dec_src2 = w_imm_sext; w_dec_dest = w_rt; w_dec_writes = 1'b1; end
      OP_SLTIU: begin w_dec_alu = ALU_SLTU; w_dec_src2 = w_imm_sext; w_dec_dest = w_rt; w_dec_writes = 1'b1; end
      OP_ANDI:  begin w_dec_alu = ALU_AND;  w_dec_src2 = w_imm_zext; w_dec_dest = w_rt; w_dec_writes = 1'b1; end
      OP_ORI:   begin w_dec_alu = ALU_OR;   w_dec_src2 = w_imm_zext; w_dec_dest = w_rt; w_dec_writes = 1'b1; end
      OP_XORI:  begin w_dec_alu = ALU_XOR;  w_dec_src2 = w_imm_zext; w_dec_dest = w_rt; w_dec_writes = 1'b1; end
      // the ALU performs the shift by 16, so LUI passes the raw immediate
      OP_LUI:   begin w_dec_alu = ALU_LUI;  w_dec_src2 = w_imm_zext; w_dec_dest = w_rt; w_dec_writes = 1'b1; end
      OP_LW:    begin w_dec_alu = ALU_ADD;  w_dec_src2 = w_imm_sext; w_dec_dest = w_rt; w_dec_writes = 1'b1; w_dec_re = 1'b1; end
      OP_SW:    begin w_dec_alu = ALU_ADD;  w_dec_src2 = w_imm_sext; w_dec_we = 1'b1; end
      default:  w_dec_illegal = 1'b1;
    endcase
  end

  // Illegal encodings carry no side effects; a zero destination never writes
  always_comb begin
    w_alu    = w_dec_alu;
    w_src2   = w_dec_src2;
    w_dest   = w_dec_dest;
    w_reg_we = 1'b0;
    w_mem_re = w_dec_re;
    w_mem_we = w_dec_we;
    if (w_dec_illegal) begin
      w_alu    = 20'h00000;
      w_src2   = 32'd0;
      w_dest   = 5'd0;
      w_mem_re = 1'b0;
      w_mem_we = 1'b0;
    end else begin
      w_reg_we = w_dec_writes && (w_dec_dest != 5'd0);
    end
  end

  // ID/EX register: valid flag, issue counter and decoded payload
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid   <= 1'b0;
      r_cnt     <= '0;
      r_pc      <= RESET_PC;
      r_alu     <= 20'h00000;
      r_src1    <= 32'd0;
      r_src2    <= 32'd0;
      r_dest    <= 5'd0;
      r_reg_we  <= 1'b0;
      r_mem_re  <= 1'b0;
      r_mem_we  <= 1'b0;
      r_store   <= 32'd0;
      r_illegal <= 1'b0;
    end else begin
      if (flush) begin
        r_valid <= 1'b0;
      end else if (w_capture) begin
        r_valid <= 1'b1;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
      // the counter tracks consumption, so a flush does not suppress it
      if (w_fire) begin
        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (w_capture) begin
        r_pc      <= in_pc;
        r_alu     <= w_alu;
        r_src1    <= w_dec_src1;
        r_src2    <= w_src2;
        r_dest    <= w_dest;
        r_reg_we  <= w_reg_we;
        r_mem_re  <= w_mem_re;
        r_mem_we  <= w_mem_we;
        r_store   <= in_rt_value;
        r_illegal <= w_dec_illegal;
      end
    end
  end

  assign out_valid       = r_valid;
  assign out_pc          = r_pc;
  assign out_alu_control = r_alu;
  assign out_alu_src1    = r_src1;
  assign out_alu_src2    = r_src2;
  assign out_dest        = r_dest;
  assign out_reg_we      = r_reg_we;
  assign out_mem_re      = r_mem_re;
  assign out_mem_we      = r_mem_we;
  assign out_store_data  = r_store;
  assign out_illegal     = r_illegal;
  assign out_issue_cnt   = r_cnt;

endmodule

// File: tb/tb_id_ex_issue.sv
// Self-checking bench for id_ex_issue (CNT_W = 4 so the counter wrap is reachable).
module tb_id_ex_issue;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_pc, in_inst, in_rs_value, in_rt_value;
  logic [31:0] out_pc, out_alu_src1, out_alu_src2, out_store_data;
  logic [19:0] out_alu_control;
  logic [4:0]  out_dest;
  logic        out_reg_we, out_mem_re, out_mem_we, out_illegal;
  logic [3:0]  out_issue_cnt;

  always #5 clk = ~clk;

  id_ex_issue #(.RESET_PC(RESET_PC), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .in_rs_value(in_rs_value), .in_rt_value(in_rt_value),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_alu_control(out_alu_control), .out_alu_src1(out_alu_src1),
    .out_alu_src2(out_alu_src2), .out_dest(out_dest), .out_reg_we(out_reg_we),
    .out_mem_re(out_mem_re), .out_mem_we(out_mem_we), .out_store_data(out_store_data),
    .out_illegal(out_illegal), .out_issue_cnt(out_issue_cnt)
  );

  typedef struct {
    logic [31:0] pc, src1, src2, store;
    logic [19:0] alu;
    logic [4:0]  dest;
    logic        we, re, mwe, illegal;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  bit          m_known = 1'b0;
  bit          m_valid = 1'b0;
  bit          m_acc = 1'b0;
  logic [3:0]  m_cnt = 4'd0;
  logic [31:0] tbl[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int sh, input logic [5:0] fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  // Reference decode, written from the instruction list
  function automatic exp_t model(input logic [31:0] pc, input logic [31:0] inst,
                                 input logic [31:0] rs, input logic [31:0] rt);
    exp_t e;
    logic [5:0] op, fn;
    logic [31:0] sx, zx, sh;
    int bitn;
    bit writes;
    op = inst[31:26]; fn = inst[5:0];
    sx = {{16{inst[15]}}, inst[15:0]};
    zx = {16'h0000, inst[15:0]};
    sh = {27'd0, inst[10:6]};
    e.pc = pc; e.store = rt; e.src1 = rs; e.src2 = rt; e.dest = 5'd0;
    e.re = 1'b0; e.mwe = 1'b0; writes = 1'b0; bitn = -1;
    if (op == 6'h00) begin
      writes = 1'b1; e.dest = inst[15:11];
      case (fn)
        6'h21: bitn = 0;
        6'h23: bitn = 1;
        6'h2A: bitn = 2;
        6'h2B: bitn = 3;
        6'h24: bitn = 4;
        6'h27: bitn = 5;
        6'h25: bitn = 6;
        6'h26: bitn = 7;
        6'h00: begin bitn = 8;  e.src1 = sh; end
        6'h02: begin bitn = 9;  e.src1 = sh; end
        6'h03: begin bitn = 10; e.src1 = sh; end
        6'h04: begin bitn = 8;  e.src1 = {27'd0, rs[4:0]}; end
        6'h06: begin bitn = 9;  e.src1 = {27'd0, rs[4:0]}; end
        6'h07: begin bitn = 10; e.src1 = {27'd0, rs[4:0]}; end
        default: bitn = -1;
      endcase
    end else begin
      case (op)
        6'h09: begin bitn = 0;  e.src2 = sx; e.dest = inst[20:16]; writes = 1'b1; end
        6'h0A: begin bitn = 2;  e.src2 = sx; e.dest = inst[20:16]; writes = 1'b1; end
        6'h0B: begin bitn = 3;  e.src2 = sx; e.dest = inst[20:16]; writes = 1'b1; end
        6'h0C: begin bitn = 4;  e.src2 = zx; e.dest = inst[20:16]; writes = 1'b1; end
        6'h0D: begin bitn = 6;  e.src2 = zx; e.dest = inst[20:16]; writes = 1'b1; end
        6'h0E: begin bitn = 7;  e.src2 = zx; e.dest = inst[20:16]; writes = 1'b1; end
        6'h0F: begin bitn = 11; e.src2 = zx; e.dest = inst[20:16]; writes = 1'b1; end
        6'h23: begin bitn = 0;  e.src2 = sx; e.dest = inst[20:16]; writes = 1'b1; e.re = 1'b1; end
        6'h2B: begin bitn = 0;  e.src2 = sx; e.mwe = 1'b1; end
        6'h01: begin
          e.src2 = 32'd0;
          if (inst[20:16] == 5'd0) bitn = 14;
          else if (inst[20:16] == 5'd1) bitn = 17;
          else bitn = -1;
        end
        6'h06: begin bitn = 15; e.src2 = 32'd0; end
        6'h07: begin bitn = 16; e.src2 = 32'd0; end
        6'h04: bitn = 18;
        6'h05: bitn = 19;
        default: bitn = -1;
      endcase
    end
    if (bitn < 0) begin
      e.illegal = 1'b1; e.alu = 20'd0; e.dest = 5'd0; e.we = 1'b0; e.re = 1'b0; e.mwe = 1'b0;
    end else begin
      e.illegal = 1'b0;
      e.alu = 20'd1 << bitn;
      e.we = writes && (e.dest != 5'd0);
    end
    return e;
  endfunction

  // One clock: predict, step, compare against the scoreboard head
  task automatic tick();
    bit hs, acc;
    exp_t e;
    #1;
    if (m_known) chk("in_ready", {31'd0, in_ready}, {31'd0, (!m_valid || out_ready)});
    hs  = m_valid && out_ready;
    acc = in_valid && (!m_valid || out_ready) && !flush;
    e   = model(in_pc, in_inst, in_rs_value, in_rt_value);
    @(posedge clk); #1;
    m_acc = 1'b0;
    if (reset) begin
      m_valid = 1'b0; m_cnt = 4'd0; sb.delete();
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_pc", out_pc, RESET_PC);
      chk("rst_cnt", {28'd0, out_issue_cnt}, 32'd0);
      chk("rst_alu", {12'd0, out_alu_control}, 32'd0);
      chk("rst_src1", out_alu_src1, 32'd0);
      chk("rst_src2", out_alu_src2, 32'd0);
      chk("rst_store", out_store_data, 32'd0);
      chk("rst_flags", {26'd0, out_dest, out_reg_we, out_mem_re, out_mem_we, out_illegal}, 32'd0);
    end else begin
      if (hs) begin m_cnt = m_cnt + 4'd1; void'(sb.pop_front()); end
      if (flush) begin m_valid = 1'b0; sb.delete(); end
      else if (acc) begin m_valid = 1'b1; m_acc = 1'b1; sb.push_back(e); end
      else if (hs) m_valid = 1'b0;
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      chk("issue_cnt", {28'd0, out_issue_cnt}, {28'd0, m_cnt});
      if (m_valid && sb.size() == 0) chk("sb_empty", 32'd1, 32'd0);
      if (m_valid && sb.size() > 0) begin
        e = sb[0];
        chk("pc", out_pc, e.pc);
        chk("alu", {12'd0, out_alu_control}, {12'd0, e.alu});
        chk("illegal", {31'd0, out_illegal}, {31'd0, e.illegal});
        chk("dest", {27'd0, out_dest}, {27'd0, e.dest});
        chk("ctl", {29'd0, out_reg_we, out_mem_re, out_mem_we}, {29'd0, e.we, e.re, e.mwe});
        chk("store", out_store_data, e.store);
        if (!e.illegal) begin
          chk("src1", out_alu_src1, e.src1);
          chk("src2", out_alu_src2, e.src2);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = 32'd0; in_inst = 32'd0; in_rs_value = 32'd0; in_rt_value = 32'd0;
    @(posedge clk); #1;
    m_known = 1'b1;
    // reset dominates flush and a live handshake
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_inst = 32'h2422_FFFF;
    tick();

    reset = 1'b0; flush = 1'b0;
    in_pc = 32'h0000_0100; in_inst = 32'h2422_FFFF; in_rs_value = 32'd5; in_rt_value = 32'h77;
    tick();
    chk("addiu_alu", {12'd0, out_alu_control}, 32'h0000_0001);
    chk("addiu_src1", out_alu_src1, 32'd5);
    chk("addiu_src2", out_alu_src2, 32'hFFFF_FFFF);
    chk("addiu_dest", {27'd0, out_dest}, 32'd2);
    chk("addiu_we", {31'd0, out_reg_we}, 32'd1);

    in_pc = 32'h0000_0104; in_inst = 32'h0004_19C0; in_rs_value = 32'h1234_5678; in_rt_value = 32'hF0;
    tick();
    chk("sll_alu", {12'd0, out_alu_control}, 32'h0000_0100);
    chk("sll_src1", out_alu_src1, 32'd7);
    chk("sll_src2", out_alu_src2, 32'hF0);
    chk("sll_dest", {27'd0, out_dest}, 32'd3);

    in_pc = 32'h0000_0108; in_inst = 32'h3C05_1234;
    tick();
    chk("lui_alu", {12'd0, out_alu_control}, 32'h0000_0800);
    chk("lui_src2", out_alu_src2, 32'h0000_1234);
    chk("lui_dest", {27'd0, out_dest}, 32'd5);

    in_pc = 32'h0000_010C; in_inst = 32'hFC00_0000;
    tick();
    chk("ill_flag", {31'd0, out_illegal}, 32'd1);
    chk("ill_alu", {12'd0, out_alu_control}, 32'd0);
    chk("ill_we", {31'd0, out_reg_we}, 32'd0);

    // backpressure from a clean reset so the counter starts at zero
    in_valid = 1'b0; reset = 1'b1; tick(); reset = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1;
    in_pc = 32'h0000_0110; in_inst = rtype(1, 2, 9, 0, 6'h21); in_rs_value = 32'd10; in_rt_value = 32'd20;
    tick();
    in_pc = 32'h0000_0114; in_inst = rtype(3, 4, 10, 0, 6'h23); in_rs_value = 32'd30; in_rt_value = 32'd40;
    tick();
    chk("bp_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("bp_pc_hold", out_pc, 32'h0000_0110);
    out_ready = 1'b1;
    tick();
    chk("bp_next_pc", out_pc, 32'h0000_0114);
    chk("bp_cnt", {28'd0, out_issue_cnt}, 32'd1);

    // flush while stalled: entry and simultaneous input both dropped
    flush = 1'b1; out_ready = 1'b0; in_pc = 32'h0000_0118; in_inst = itype(6'h0D, 1, 6, 16'h8001);
    tick();
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    flush = 1'b0; in_valid = 1'b0;
    tick();
    // flush coinciding with a handshake still counts it
    in_valid = 1'b1; out_ready = 1'b1; in_pc = 32'h0000_011C; in_inst = itype(6'h23, 2, 7, 16'hFFF0);
    tick();
    flush = 1'b1;
    tick();
    chk("flush_hs_cnt", {28'd0, out_issue_cnt}, 32'd2);
    flush = 1'b0;

    // reset in the middle of backpressure
    out_ready = 1'b0; in_inst = itype(6'h2B, 3, 8, 16'h0004);
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // 16 handshakes wrap the 4-bit counter back to zero
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_pc = 32'h0000_1000 + 32'(i * 4);
      in_inst = itype(6'h09, i, i + 1, 16'(i));
      in_rs_value = $urandom(); in_rt_value = $urandom();
      tick();
    end
    chk("wrap_cnt15", {28'd0, out_issue_cnt}, 32'd15);
    in_valid = 1'b0;
    tick();
    chk("wrap_cnt0", {28'd0, out_issue_cnt}, 32'd0);

    // every opcode/funct with random operands and random backpressure
    tbl.push_back(rtype(1, 2, 3, 0, 6'h21)); tbl.push_back(rtype(1, 2, 3, 0, 6'h23));
    tbl.push_back(rtype(4, 5, 6, 0, 6'h2A)); tbl.push_back(rtype(4, 5, 6, 0, 6'h2B));
    tbl.push_back(rtype(7, 8, 9, 0, 6'h24)); tbl.push_back(rtype(7, 8, 9, 0, 6'h27));
    tbl.push_back(rtype(7, 8, 9, 0, 6'h25)); tbl.push_back(rtype(7, 8, 9, 0, 6'h26));
    tbl.push_back(rtype(0, 8, 11, 31, 6'h00)); tbl.push_back(rtype(0, 8, 12, 1, 6'h02));
    tbl.push_back(rtype(0, 8, 13, 17, 6'h03)); tbl.push_back(rtype(2, 8, 14, 0, 6'h04));
    tbl.push_back(rtype(2, 8, 15, 0, 6'h06)); tbl.push_back(rtype(2, 8, 16, 0, 6'h07));
    tbl.push_back(rtype(1, 2, 0, 0, 6'h21)); tbl.push_back(rtype(1, 2, 3, 0, 6'h3F));
    tbl.push_back(itype(6'h09, 1, 0, 16'h0010)); tbl.push_back(itype(6'h0A, 1, 17, 16'h8000));
    tbl.push_back(itype(6'h0B, 1, 18, 16'hFFFE)); tbl.push_back(itype(6'h0C, 1, 19, 16'h8765));
    tbl.push_back(itype(6'h0D, 1, 20, 16'hF00F)); tbl.push_back(itype(6'h0E, 1, 21, 16'hA5A5));
    tbl.push_back(itype(6'h0F, 0, 22, 16'hBEEF)); tbl.push_back(itype(6'h23, 1, 23, 16'h8004));
    tbl.push_back(itype(6'h2B, 1, 24, 16'h0008)); tbl.push_back(itype(6'h01, 1, 0, 16'h0003));
    tbl.push_back(itype(6'h01, 1, 1, 16'h0003)); tbl.push_back(itype(6'h01, 1, 2, 16'h0003));
    tbl.push_back(itype(6'h06, 1, 0, 16'hFFFC)); tbl.push_back(itype(6'h07, 1, 0, 16'h0010));
    tbl.push_back(itype(6'h04, 1, 2, 16'h0020)); tbl.push_back(itype(6'h05, 1, 2, 16'h0020));
    tbl.push_back(itype(6'h3F, 1, 2, 16'h0000));
    for (int j = 0; j < tbl.size(); j++) begin
      in_inst = tbl[j];
      in_pc = 32'h0000_2000 + 32'(j * 4);
      in_rs_value = $urandom(); in_rt_value = $urandom();
      in_valid = 1'b1;
      m_acc = 1'b0;
      for (int k = 0; k < 50 && !m_acc; k++) begin
        out_ready = ($urandom_range(0, 3) != 0);
        tick();
      end
      if (!m_acc) chk("sweep_accept", 32'd0, 32'd1);
      if ($urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        tick();
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
